// File: rtl/ws2812_rx.sv
// WS2812 line receiver: classifies high-pulse widths into bits, assembles 24-bit pixels, detects latch gaps.
// All strobes are registered and land three cycles after the pin edge that causes them.
module ws2812_rx #(
  parameter int T_MIN_HIGH   = 2,
  parameter int T_BIT_THRESH = 6,
  parameter int T_MAX_HIGH   = 15,
  parameter int T_RESET      = 600,
  parameter int IDX_W        = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ws_data,
  output logic [23:0]      pixel,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_idx,
  output logic             frame_done,
  output logic [IDX_W-1:0] frame_pixels,
  output logic             err
);
  localparam int HW = $clog2(T_MAX_HIGH + 2);
  localparam int LW = $clog2(T_RESET + 1);
  localparam logic [HW-1:0] H_MIN = HW'(T_MIN_HIGH);
  localparam logic [HW-1:0] H_THR = HW'(T_BIT_THRESH);
  localparam logic [HW-1:0] H_MAX = HW'(T_MAX_HIGH);
  localparam logic [HW-1:0] H_SAT = HW'(T_MAX_HIGH + 1);
  localparam logic [LW-1:0] L_SAT = LW'(T_RESET);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             s_q, s_d;
  logic             s_prev_q, s_prev_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [LW-1:0]    lcnt_q, lcnt_d;
  logic             fired_q, fired_d;
  logic [22:0]      sh_q, sh_d;
  logic [4:0]       bcnt_q, bcnt_d;
  logic [IDX_W-1:0] pcnt_q, pcnt_d;
  logic [23:0]      pixel_q, pixel_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic [IDX_W-1:0] pixel_idx_q, pixel_idx_d;
  logic             frame_done_q, frame_done_d;
  logic [IDX_W-1:0] frame_pixels_q, frame_pixels_d;
  logic             err_q, err_d;
  logic             rise, latch_evt, fault, bit_vld, bit_val;

  always_comb begin
    sync1_d        = ws_data;
    s_d            = sync1_q;
    s_prev_d       = s_q;
    hcnt_d         = s_q ? ((hcnt_q == H_SAT) ? H_SAT : hcnt_q + 1'b1) : '0;
    lcnt_d         = s_q ? '0 : ((lcnt_q == L_SAT) ? L_SAT : lcnt_q + 1'b1);
    // fired marks a low period whose gap has already been consumed, so a saturated counter never retriggers
    fired_d        = !s_q && (fired_q || (lcnt_q == L_SAT));
    state_d        = state_q;
    sh_d           = sh_q;
    bcnt_d         = bcnt_q;
    pcnt_d         = pcnt_q;
    pixel_d        = pixel_q;
    pixel_idx_d    = pixel_idx_q;
    frame_pixels_d = frame_pixels_q;
    pixel_valid_d  = 1'b0;
    frame_done_d   = 1'b0;
    err_d          = 1'b0;
    fault          = 1'b0;
    bit_vld        = 1'b0;
    bit_val        = 1'b0;
    rise           = s_q && !s_prev_q;
    latch_evt      = (lcnt_q == L_SAT) && !fired_q;

    case (state_q)
      SYNC: begin
        // a gap of exactly T_RESET may be followed at once by a pulse; catch its rising edge here
        if (lcnt_q == L_SAT) state_d = rise ? HIGH : IDLE;
      end
      IDLE: begin
        if (latch_evt) begin
          frame_done_d   = 1'b1;
          frame_pixels_d = pcnt_q;
          pcnt_d         = '0;
          pixel_idx_d    = '0;
          bcnt_d         = '0;
          if (bcnt_q != 5'd0) err_d = 1'b1;
        end
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (hcnt_q > H_MAX) begin
          fault = 1'b1;
        end else if (!s_q) begin
          state_d = IDLE;
          if (hcnt_q < H_MIN) begin
            fault = 1'b1;
          end else begin
            bit_vld = 1'b1;
            bit_val = (hcnt_q >= H_THR);
          end
        end
      end
      default: state_d = SYNC;
    endcase

    if (bit_vld) begin
      if (bcnt_q == 5'd23) begin
        pixel_d       = {sh_q, bit_val};
        pixel_valid_d = 1'b1;
        pixel_idx_d   = pcnt_q;
        pcnt_d        = pcnt_q + 1'b1;
        bcnt_d        = '0;
      end else begin
        sh_d   = {sh_q[21:0], bit_val};
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    if (fault) begin
      err_d   = 1'b1;
      state_d = SYNC;
      bcnt_d  = '0;
      pcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= SYNC;
      sync1_q        <= 1'b0;
      s_q            <= 1'b0;
      s_prev_q       <= 1'b0;
      hcnt_q         <= '0;
      lcnt_q         <= '0;
      fired_q        <= 1'b0;
      sh_q           <= '0;
      bcnt_q         <= '0;
      pcnt_q         <= '0;
      pixel_q        <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_idx_q    <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      s_q            <= s_d;
      s_prev_q       <= s_prev_d;
      hcnt_q         <= hcnt_d;
      lcnt_q         <= lcnt_d;
      fired_q        <= fired_d;
      sh_q           <= sh_d;
      bcnt_q         <= bcnt_d;
      pcnt_q         <= pcnt_d;
      pixel_q        <= pixel_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_idx_q    <= pixel_idx_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      err_q          <= err_d;
    end
  end

  assign pixel        = pixel_q;
  assign pixel_valid  = pixel_valid_q;
  assign pixel_idx    = pixel_idx_q;
  assign frame_done   = frame_done_q;
  assign frame_pixels = frame_pixels_q;
  assign err          = err_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// Randomised and directed line stimulus for ws2812_rx; a run-length model predicts each strobe
// and its cycle, and a monitor pops predictions whenever the receiver strobes.
module tb_ws2812_rx;
  localparam int T_MIN = 2;
  localparam int T_THR = 6;
  localparam int T_MAX = 15;
  localparam int T_RST = 600;
  localparam int IDX_W = 3;
  localparam int NPIX  = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             ws_data = 1'b0;
  logic [23:0]      pixel;
  logic             pixel_valid;
  logic [IDX_W-1:0] pixel_idx;
  logic             frame_done;
  logic [IDX_W-1:0] frame_pixels;
  logic             err;

  ws2812_rx #(.T_MIN_HIGH(T_MIN), .T_BIT_THRESH(T_THR), .T_MAX_HIGH(T_MAX),
              .T_RESET(T_RST), .IDX_W(IDX_W)) dut (
    .clk(clk), .resetn(resetn), .ws_data(ws_data), .pixel(pixel), .pixel_valid(pixel_valid),
    .pixel_idx(pixel_idx), .frame_done(frame_done), .frame_pixels(frame_pixels), .err(err));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit pv, fd, er;
    logic [23:0] px;
    int idx, fp;
  } ev_t;
  ev_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: decoding allowed, partial word, counts and the values the outputs hold.
  bit          m_sync = 1'b1;
  logic [23:0] m_sh = '0;
  logic [23:0] m_px = '0;
  int          m_nb = 0, m_np = 0, m_idx = 0, m_fp = 0;
  int unsigned m_low_start = 0;
  int          m_low_len = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int unsigned t, input bit pv, input bit fd, input bit er);
    ev_t e;
    e.cyc = t; e.pv = pv; e.fd = fd; e.er = er;
    e.px = m_px; e.idx = m_idx; e.fp = m_fp;
    exp_q.push_back(e);
  endtask

  task automatic model_error(input int unsigned t);
    m_sync = 1'b1; m_nb = 0; m_np = 0;
    push_ev(t, 1'b0, 1'b0, 1'b1);
  endtask

  // Consecutive low runs merge into one gap; a high run of N samples starting at edge e0 ends at e0+N.
  task automatic model_run(input bit lvl, input int len, input int unsigned e0);
    int prev;
    if (lvl) begin
      m_low_len = 0;
      if (!m_sync) begin
        if (len > T_MAX) model_error(e0 + T_MAX + 3);
        else if (len < T_MIN) model_error(e0 + len + 2);
        else begin
          m_sh = {m_sh[22:0], (len >= T_THR)};
          m_nb++;
          if (m_nb == 24) begin
            m_px = m_sh; m_idx = m_np; m_np = (m_np + 1) % NPIX; m_nb = 0;
            push_ev(e0 + len + 2, 1'b1, 1'b0, 1'b0);
          end
        end
      end
    end else begin
      if (m_low_len == 0) m_low_start = e0;
      prev = m_low_len;
      m_low_len += len;
      if (prev < T_RST && m_low_len >= T_RST) begin
        if (m_sync) m_sync = 1'b0;
        else begin
          m_fp = m_np; m_np = 0; m_idx = 0;
          push_ev(m_low_start + T_RST + 2, 1'b0, 1'b1, m_nb != 0);
          m_nb = 0;
        end
      end
    end
  endtask

  task automatic run(input bit lvl, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) model_run(lvl, len, cyc + 1);
      ws_data = lvl;
    end
  endtask

  task automatic send_bit(input bit b, input bit rnd);
    int hi, lo;
    if (rnd) begin
      hi = b ? int'($urandom_range(T_MAX, T_THR)) : int'($urandom_range(T_THR - 1, T_MIN));
      lo = int'($urandom_range(12, 1));
    end else begin
      hi = b ? 8 : 4;
      lo = b ? 7 : 11;
    end
    run(1'b1, hi);
    run(1'b0, lo);
  endtask

  task automatic send_word(input logic [23:0] v, input int nbits, input bit rnd);
    for (int i = 0; i < nbits; i++) send_bit(v[23 - i], rnd);
  endtask

  task automatic do_reset();
    @(negedge clk); resetn = 1'b0; ws_data = 1'b0;
    @(negedge clk); resetn = 1'b1;
    m_sync = 1'b1; m_nb = 0; m_np = 0; m_px = '0; m_idx = 0; m_fp = 0; m_sh = '0; m_low_len = 0;
    check("rst_pixel", pixel, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pixel_idx", pixel_idx, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_pixels", frame_pixels, 0);
    check("rst_err", err, 0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (resetn && (pixel_valid || frame_done || err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {pixel_valid, frame_done, err}, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_kind", {pixel_valid, frame_done, err}, {e.pv, e.fd, e.er});
        check("pixel", pixel, e.px);
        check("pixel_idx", pixel_idx, e.idx);
        check("frame_pixels", frame_pixels, e.fp);
      end
    end
  end

  initial begin
    int r;
    do_reset();
    // 1: single pixel with nominal widths
    run(1'b0, 610);
    send_word(24'hFF0080, 24, 1'b0);
    run(1'b0, 700);
    // 2: three pixels back to back
    send_word(24'h000001, 24, 1'b0);
    send_word(24'h800000, 24, 1'b0);
    send_word(24'h5A5A5A, 24, 1'b0);
    run(1'b0, 650);
    // 3: widths 5/6 straddle the threshold, then minimum-width and glitch pulses
    for (int i = 0; i < 24; i++) begin
      run(1'b1, (i % 2 == 0) ? 5 : 6);
      run(1'b0, 7);
    end
    run(1'b1, 2); run(1'b0, 7);
    run(1'b1, 1); run(1'b0, 7);
    send_word(24'h123456, 24, 1'b1);
    run(1'b0, 650);
    // 4: partial pixel closed by an exact T_RESET gap with a pulse right behind it
    send_word(24'hABCDEF, 9, 1'b1);
    run(1'b1, 8); run(1'b0, T_RST);
    send_word(24'hC3C3C3, 24, 1'b1);
    run(1'b0, 650);
    // 5: over-long pulse mid-pixel; later bits ignored until resync
    send_word(24'hF0F0F0, 5, 1'b1);
    run(1'b1, 20); run(1'b0, 6);
    send_word(24'hFFFFFF, 24, 1'b1);
    run(1'b0, 650);
    send_word(24'h0F1E2D, 24, 1'b1);
    run(1'b0, 650);
    // 6: reset at bit 12
    send_word(24'h777777, 12, 1'b1);
    run(1'b0, 4);
    do_reset();
    send_word(24'hFFFFFF, 24, 1'b1);
    run(1'b0, 650);
    send_word(24'h00FF00, 24, 1'b1);
    run(1'b0, 650);
    // pixel counter wrap within one frame
    for (int p = 0; p < NPIX + 2; p++) send_word(24'($urandom), 24, 1'b1);
    run(1'b0, 650);
    // random mix
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(9, 0));
      case (r)
        0: begin run(1'b1, 1); run(1'b0, int'($urandom_range(10, 1))); end
        1: begin run(1'b1, int'($urandom_range(30, T_MAX + 1))); run(1'b0, int'($urandom_range(10, 1))); end
        2, 3: run(1'b0, int'($urandom_range(T_RST + 100, T_RST)));
        4: send_word(24'($urandom), int'($urandom_range(23, 1)), 1'b1);
        default: send_word(24'($urandom), 24, 1'b1);
      endcase
    end
    run(1'b0, 700);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("missing_strobes", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Serial receiver/decoder for the WS2812 single-wire LED protocol that the top-level `ws_data` output drives. Samples a `ws_data`-style line, classifies each high pulse as a 0 or 1 bit by width, assembles 24-bit pixel words, and detects the latch (reset) gap that ends a frame. Used as an in-fabric loopback monitor on the LED driver output and as the input stage for chained-display builds. Pulse-width thresholds are cycle counts, sized for the 12 MHz board clock.

## Interface

Parameters:
- `T_MIN_HIGH`, default 2: shortest legal high pulse, in cycles. Anything shorter is a glitch error.
- `T_BIT_THRESH`, default 6: high width at or above this value decodes as 1; below it decodes as 0.
- `T_MAX_HIGH`, default 15: longest legal high pulse, in cycles. Anything longer is an error.
- `T_RESET`, default 600: low-time that constitutes a latch gap (50 µs at 12 MHz).
- `IDX_W`, default 8: width of the pixel index and pixel count outputs.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `ws_data` in 1: asynchronous serial line.
- `pixel` out 24: last complete pixel; first received bit lands in bit 23.
- `pixel_valid` out 1: one-cycle strobe when `pixel` is updated.
- `pixel_idx` out IDX_W: position of `pixel` within the current frame, starting at 0.
- `frame_done` out 1: one-cycle strobe when a latch gap is detected.
- `frame_pixels` out IDX_W: count of complete pixels in the last frame; updated with `frame_done`.
- `err` out 1: one-cycle strobe on any protocol violation.

## Operation

Input conditioning:
- `ws_data` passes through a 2-flop synchroniser to give `s`.
- `s` is registered once more for edge detection.

Counters:
- High counter: counts cycles with `s`=1 and saturates at `T_MAX_HIGH`+1.
- Low counter: counts cycles with `s`=0 and saturates at `T_RESET`.
- Each counter clears on the opposite level.

FSM states:
- SYNC: entered on reset and after every error.
  - Decodes nothing.
  - Any `s`=1 clears the low counter.
  - When the low counter reaches `T_RESET`, go to IDLE. No `frame_done` is issued on this transition.
- IDLE: line low, waiting for a pulse.
  - Rising edge: go to HIGH.
  - Low counter reaches `T_RESET`: issue the latch event, stay in IDLE.
- HIGH: counting the pulse width.
  - If the high counter exceeds `T_MAX_HIGH`: pulse `err`, go to SYNC.
  - On the falling edge with width H:
    - H < `T_MIN_HIGH`: pulse `err`, go to SYNC.
    - Otherwise the bit is (H >= `T_BIT_THRESH`). Shift it into the pixel register MSB-first, increment the bit count, go to IDLE.
- 24th bit: `pixel` is loaded and `pixel_valid` is pulsed with the current `pixel_idx`. After that, the bit count returns to 0 and the pixel counter increments.

Latch event:
- Pulse `frame_done`.
- `frame_pixels` is set to the pixel counter.
- Pixel counter and `pixel_idx` are set to 0.
- If the bit count is nonzero: the partial pixel is discarded, `err` pulses in the same cycle, and the bit count clears.
- Only one latch event per low period; the saturated low counter does not retrigger it.

Wrap and error rules:
- The pixel counter wraps modulo 2^IDX_W. `frame_pixels` reports the wrapped value.
- An error discards any partial pixel, clears the bit count, and resets the pixel counter to 0.
- Pixels already strobed in that frame are not retracted.

## Timing

- Reset values: `pixel`=0, `pixel_valid`=0, `pixel_idx`=0, `frame_done`=0, `frame_pixels`=0, `err`=0; FSM in SYNC.
- `resetn` low mid-pixel or mid-frame gives the same reset values on the next edge. Partial data is lost.
- Latency:
  - `pixel_valid` asserts 3 cycles after the falling edge of the 24th bit at the `ws_data` pin (2 synchroniser cycles + 1 register).
  - `frame_done` asserts 3 cycles after the low counter would reach `T_RESET` measured at the pin.
- Pulse width H is measured on `s`. A pin-level high of N cycles gives H=N.
- `pixel_valid` and `frame_done` never assert in the same cycle. This holds because a latch requires at least `T_RESET` low cycles after the last falling edge.
- `err` can coincide with `frame_done` (partial-pixel case).
- `pixel` and `pixel_idx` hold their values between strobes.

## Test plan

1. Reset, hold the line low for 600 cycles, then send 0xFF0080 (1 = 8 high / 7 low, 0 = 4 high / 11 low), then 700 cycles low. Required: `pixel_valid` once with `pixel`=0xFF0080 and `pixel_idx`=0; then `frame_done` with `frame_pixels`=1; `err` never asserts.
2. Sync, then three pixels back to back (0x000001, 0x800000, 0x5A5A5A), then a gap. Required: strobes with idx 0, 1, 2 and those values; `frame_pixels`=3.
3. Threshold boundary: a 24-bit word of alternating high widths 5 and 6 cycles, starting with 5. Required: `pixel`=0x555555. Then a 2-cycle high decodes as 0 without error, and a 1-cycle high gives `err` and a return to SYNC.
4. Send 10 bits, then a 600-cycle gap. Required: `err` and `frame_done` in the same cycle, no `pixel_valid`, `frame_pixels`=0. The next pixel is reported at idx 0.
5. A 20-cycle high mid-pixel. Required: `err` 3 cycles after the 16th high cycle. Following bits are ignored until 600 low cycles have elapsed, after which decoding resumes.
6. Drive `resetn` low for 1 cycle at bit 12 of a pixel. Required: all outputs return to their reset values. With no prior 600-cycle low, following bits produce no `pixel_valid`.
